// File: rtl/padding_ctrl.sv
// Frame sequencer for the padding line buffer: one zero row, IMG_H source rows, one zero row,
// streamed one pixel per cycle, with a stall after every 3-row window until the consumer acks.
module padding_ctrl #(
    parameter int IMG_W = 416,
    parameter int IMG_H = 416,
    parameter int RW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic [7:0]    src_R,
    input  logic [7:0]    src_G,
    input  logic [7:0]    src_B,
    output logic          padding_en,
    output logic          imgDataValid,
    output logic [7:0]    R_input,
    output logic [7:0]    G_input,
    output logic [7:0]    B_input,
    input  logic          pad_intr,
    output logic          win_valid,
    input  logic          win_ack,
    output logic [RW-1:0] win_row,
    output logic          proto_err
);

    typedef enum logic [2:0] {IDLE, TOP, STREAM, BOT, WAIT_WIN, DONE} state_t;

    localparam logic [RW-1:0] COL_LAST    = RW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_SRC_END = RW'(IMG_H + 1);

    state_t        state;
    logic [RW-1:0] col;
    logic [RW-1:0] row;
    logic [RW-1:0] row_inc;
    logic          accept;

    always_comb begin
        row_inc = row + RW'(1);
        accept  = src_valid && src_ready;
    end

    // row counts padded rows already fed to the padding block (zero rows included)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            src_ready    <= 1'b0;
            padding_en   <= 1'b0;
            imgDataValid <= 1'b0;
            R_input      <= '0;
            G_input      <= '0;
            B_input      <= '0;
            win_valid    <= 1'b0;
            win_row      <= '0;
            proto_err    <= 1'b0;
        end else begin
            imgDataValid <= 1'b0;
            done         <= 1'b0;
            if (pad_intr && state != WAIT_WIN)
                proto_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= TOP;
                        col        <= '0;
                        row        <= '0;
                        win_row    <= '0;
                        proto_err  <= 1'b0;
                        busy       <= 1'b1;
                        padding_en <= 1'b1;
                    end
                end

                TOP, BOT: begin
                    imgDataValid <= 1'b1;
                    R_input      <= '0;
                    G_input      <= '0;
                    B_input      <= '0;
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (state == TOP) begin
                            row       <= RW'(1);
                            state     <= STREAM;
                            src_ready <= 1'b1;
                        end else begin
                            row   <= row_inc;
                            state <= WAIT_WIN;
                        end
                    end else begin
                        col <= col + RW'(1);
                    end
                end

                STREAM: begin
                    if (accept) begin
                        imgDataValid <= 1'b1;
                        R_input      <= src_R;
                        G_input      <= src_G;
                        B_input      <= src_B;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row_inc;
                            // a full window takes priority over the bottom row
                            if (row_inc >= RW'(3)) begin
                                state     <= WAIT_WIN;
                                src_ready <= 1'b0;
                            end else if (row_inc == ROW_SRC_END) begin
                                state     <= BOT;
                                src_ready <= 1'b0;
                            end
                        end else begin
                            col <= col + RW'(1);
                        end
                    end
                end

                WAIT_WIN: begin
                    if (win_valid) begin
                        if (win_ack) begin
                            win_valid <= 1'b0;
                            win_row   <= win_row + RW'(1);
                            if (row < ROW_SRC_END) begin
                                state     <= STREAM;
                                src_ready <= 1'b1;
                            end else if (row == ROW_SRC_END) begin
                                state <= BOT;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end else if (pad_intr) begin
                        win_valid <= 1'b1;
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    padding_en <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_padding_ctrl.sv
// Scoreboard bench for padding_ctrl on a 4x3 image: expected pixels and window rows are queued
// as stimulus is issued and popped as the design produces them.
module tb_padding_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int RW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          src_valid = 1'b0;
    logic [7:0]    src_R = '0, src_G = '0, src_B = '0;
    logic          pad_intr = 1'b0;
    logic          win_ack = 1'b0;
    logic          busy, done, src_ready, padding_en, imgDataValid;
    logic [7:0]    R_input, G_input, B_input;
    logic          win_valid, proto_err;
    logic [RW-1:0] win_row;

    int checks = 0;
    int errors = 0;

    logic [23:0]   exp_pix[$];
    logic [RW-1:0] exp_row[$];

    padding_ctrl #(.IMG_W(W), .IMG_H(H), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_R(src_R), .src_G(src_G), .src_B(src_B),
        .padding_en(padding_en), .imgDataValid(imgDataValid),
        .R_input(R_input), .G_input(G_input), .B_input(B_input),
        .pad_intr(pad_intr), .win_valid(win_valid), .win_ack(win_ack),
        .win_row(win_row), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int i);
        logic [7:0] r, g, b;
        r = 8'(i + 1);
        g = 8'(i * 3 + 7);
        b = 8'hA0 ^ 8'(i);
        return {r, g, b};
    endfunction

    // One frame: toggle = 50% src_valid, ack_delay = cycles win_valid is held before ack,
    // stray = inject pad_intr + win_ack + start together mid-STREAM.
    task automatic run_frame(input bit toggle, input int ack_delay, input bit stray, input bit exp_proto);
        int cyc = 0, src_idx = 0, out_cnt = 0, hold = 0, windows = 0, done_cnt = 0, intr_timer = -1;
        bit prev_valid = 0, prev_ready = 0, acking = 0, intr_chk = 0;
        bit stray_done = 0, stray_rel = 0, stall_bad = 0, fin = 0;
        logic [23:0] e;
        exp_pix.delete();
        exp_row.delete();
        repeat (W) exp_pix.push_back('0);
        for (int r = 0; r < H; r++) exp_row.push_back(RW'(r));
        @(negedge clk);
        start = 1'b1;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (stray_rel) begin
                pad_intr  = 1'b0;
                win_ack   = 1'b0;
                stray_rel = 0;
            end
            if (prev_valid && prev_ready) begin
                exp_pix.push_back(pix(src_idx));
                src_idx++;
                if (src_idx == W * H) repeat (W) exp_pix.push_back('0);
            end
            if (intr_chk) begin
                check("win_latency", win_valid, 1);
                pad_intr = 1'b0;
                intr_chk = 0;
            end
            if (intr_timer == 0) begin
                pad_intr   = 1'b1;
                intr_chk   = 1;
                intr_timer = -1;
            end
            if (imgDataValid) begin
                out_cnt++;
                if (exp_pix.size() == 0) check("pix_extra", 1, 0);
                else begin
                    e = exp_pix.pop_front();
                    check("pix", {8'h0, R_input, G_input, B_input}, {8'h0, e});
                end
                if (out_cnt == 1) begin
                    check("busy_mid", busy, 1);
                    check("pad_en_mid", padding_en, 1);
                end
                if (out_cnt >= 3 * W && out_cnt % W == 0) intr_timer = 0;
            end
            if (acking) begin
                check("win_clear", win_valid, 0);
                win_ack = 1'b0;
                acking  = 0;
                windows++;
            end else if (win_valid) begin
                hold++;
                if (src_ready) stall_bad = 1;
                if (hold >= ack_delay) begin
                    if (exp_row.size() == 0) check("win_extra", 1, 0);
                    else check("win_row", win_row, exp_row.pop_front());
                    win_ack = 1'b1;
                    acking  = 1;
                    hold    = 0;
                end
            end
            if (stray && !stray_done && out_cnt == 6) begin
                stray_done = 1;
                stray_rel  = 1;
                pad_intr   = 1'b1;
                win_ack    = 1'b1;
                start      = 1'b1;
            end
            if (done) done_cnt++;
            else if (done_cnt > 0) begin
                fin = 1;
                check("busy_end", busy, 0);
                check("pad_en_end", padding_en, 0);
            end
            src_valid = (src_idx < W * H) && (!toggle || (cyc % 2 == 1));
            {src_R, src_G, src_B} = pix(src_idx);
            prev_valid = src_valid;
            prev_ready = src_ready;
        end
        src_valid = 1'b0;
        pad_intr  = 1'b0;
        win_ack   = 1'b0;
        start     = 1'b0;
        check("frame_timeout", fin, 1);
        check("pix_count", out_cnt, 2 * W + W * H);
        check("pix_left", exp_pix.size(), 0);
        check("windows", windows, H);
        check("done_pulses", done_cnt, 1);
        check("stall_ready", stall_bad, 0);
        check("proto_err", proto_err, exp_proto);
    endtask

    task automatic reset_mid_stream();
        int n = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_valid = 1'b1;
        while (!src_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_stream", src_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_valid", imgDataValid, 0);
        check("rst_win_valid", win_valid, 0);
        src_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #10;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_src_ready", src_ready, 0);
        check("reset_pad_en", padding_en, 0);
        check("reset_valid", imgDataValid, 0);
        check("reset_data", {8'h0, R_input, G_input, B_input}, 0);
        check("reset_win_valid", win_valid, 0);
        check("reset_win_row", win_row, 0);
        check("reset_proto", proto_err, 0);
        @(negedge clk);
        reset = 1'b1;

        run_frame(0, 1, 0, 0);
        run_frame(1, 1, 0, 0);
        run_frame(0, 10, 0, 0);
        run_frame(0, 1, 1, 1);
        run_frame(1, 1, 0, 0);
        reset_mid_stream();
        run_frame(0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
